// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential divider.
//   - State encoding for the divider FSM (IDLE / RUN / DONE).
//   - cnt_width(): width of the iteration counter that must hold WIDTH.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must represent the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration (purely combinational).
// Ports:
//   i_rem     [WIDTH:0]   partial remainder before the step
//   i_q_msb               MSB of the quotient shift register, shifted into rem
//   i_divisor [WIDTH-1:0] divisor
//   o_rem     [WIDTH:0]   partial remainder after the step
//   o_q_bit               quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    // One extra guard bit above the remainder width keeps the borrow of the
    // trial subtraction visible regardless of the shifted value.
    assign w_shift = {i_rem, i_q_msb};
    assign w_trial = w_shift - {2'b00, i_divisor};

    assign o_q_bit = ~w_trial[WIDTH+1];
    assign o_rem   = o_q_bit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned divider, one quotient bit per clock,
// behind a start/done handshake.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, accepted in IDLE or DONE
//   n, d  [WIDTH-1:0]  dividend / divisor, captured on the accepting edge
//   busy               high while iterating
//   done               one-cycle pulse, results valid
//   q, r  [WIDTH-1:0]  quotient / remainder, held until the next accept
//   div_by_zero        captured divisor was zero (q = all ones, r = n)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shift-subtract iterations, WIDTH cycles
// DONE  | results valid, done high; start accepted back-to-back
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_qreg;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_d_zero;
    logic [WIDTH:0]   w_rem_nxt;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_qreg_nxt;

    assign w_d_zero = (d == '0);

    // State register; busy/done are registered from the next state so they
    // track the state exactly without a decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = w_d_zero ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            IDLE, DONE: w_accept = start;
            RUN:        w_step   = 1'b1;
            default:    ;
        endcase
    end

    // Counter reaching 1 means this cycle performs the final iteration.
    assign w_last = w_step && (r_cnt == CW'(1));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_q_msb   (r_qreg[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

    assign w_qreg_nxt = {r_qreg[WIDTH-2:0], w_q_bit};

    // Operand, shift and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_qreg <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_rem  <= '0;
            r_qreg <= n;
            r_div  <= d;
            r_cnt  <= CW'(WIDTH);
            if (w_d_zero) begin
                // No iterations: the result is known on the accepting edge.
                r_q   <= '1;
                r_r   <= n;
                r_dbz <= 1'b1;
            end else begin
                r_q   <= '0;
                r_r   <= '0;
                r_dbz <= 1'b0;
            end
        end else if (w_step) begin
            r_rem  <= w_rem_nxt;
            r_qreg <= w_qreg_nxt;
            r_cnt  <= r_cnt - CW'(1);
            if (w_last) begin
                r_q <= w_qreg_nxt;
                r_r <= w_rem_nxt[WIDTH-1:0];
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  n8 = '0, d8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    logic        start16 = 1'b0;
    logic [15:0] n16 = '0, d16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] q16, r16;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .n(n8), .d(d8),
        .busy(busy8), .done(done8), .q(q8), .r(r8), .div_by_zero(dbz8)
    );

    seq_divider #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .n(n16), .d(d16),
        .busy(busy16), .done(done16), .q(q16), .r(r16), .div_by_zero(dbz16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one 8-bit operation and check it against plain integer division.
    // Returns sampled at #1 after the edge that raised done (still in DONE).
    task automatic op8(input logic [7:0] nn, input logic [7:0] dd, input bit b2b);
        int lat;
        bit busy_seen;
        bit held_bad;
        int exp_q, exp_r, exp_z, exp_lat;
        if (dd == 0) begin
            exp_q = 255; exp_r = nn; exp_z = 1; exp_lat = 1;
        end else begin
            exp_q = nn / dd; exp_r = nn % dd; exp_z = 0; exp_lat = 9;
        end
        if (!b2b) @(negedge clk);
        start8 = 1'b1; n8 = nn; d8 = dd;
        @(posedge clk); #1;
        start8 = 1'b0; n8 = $urandom; d8 = $urandom;
        lat = 1; busy_seen = 0; held_bad = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_seen = 1;
            if (q8 !== 8'd0 || r8 !== 8'd0 || dbz8 !== 1'b0) held_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        chk("done8_seen", {31'd0, done8}, 32'd1);
        chk("latency8", lat, exp_lat);
        chk("busy8_seen", {31'd0, busy_seen}, (dd != 0) ? 32'd1 : 32'd0);
        chk("busy8_at_done", {31'd0, busy8}, 32'd0);
        chk("held8_during_run", {31'd0, held_bad}, 32'd0);
        chk($sformatf("q8 %0d/%0d", nn, dd), {24'd0, q8}, exp_q);
        chk($sformatf("r8 %0d/%0d", nn, dd), {24'd0, r8}, exp_r);
        chk("dbz8", {31'd0, dbz8}, exp_z);
        if (dd != 0) begin
            chk("invariant8", q8 * dd + r8, {24'd0, nn});
            chk("r_lt_d8", {31'd0, (r8 < dd)}, 32'd1);
        end
    endtask

    task automatic op16(input logic [15:0] nn, input logic [15:0] dd);
        int lat;
        @(negedge clk);
        start16 = 1'b1; n16 = nn; d16 = dd;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done16_seen", {31'd0, done16}, 32'd1);
        chk("latency16", lat, (dd == 0) ? 32'd1 : 32'd17);
        chk($sformatf("q16 %0d/%0d", nn, dd), {16'd0, q16}, (dd == 0) ? 32'hFFFF : nn / dd);
        chk($sformatf("r16 %0d/%0d", nn, dd), {16'd0, r16}, (dd == 0) ? nn : nn % dd);
        chk("dbz16", {31'd0, dbz16}, (dd == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int lat;
        bit done_seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_q", {24'd0, q8}, 0);
        chk("rst_r", {24'd0, r8}, 0);
        chk("rst_dbz", {31'd0, dbz8}, 0);
        chk("rst_q16", {16'd0, q16}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        op8(8'd100, 8'd30, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done8}, 0);
        chk("q_held_idle", {24'd0, q8}, 3);

        op8(8'd12, 8'd13, 0);
        op8(8'd255, 8'd1, 1);
        op8(8'd7, 8'd0, 0);
        op8(8'd9, 8'd3, 0);
        op8(8'd0, 8'd0, 1);
        op8(8'd255, 8'd255, 1);
        op8(8'd254, 8'd255, 0);
        op16(16'd50000, 16'd7);
        op16(16'd65535, 16'd65535);
        op16(16'd1234, 16'd0);

        // Start mid-RUN is ignored
        @(negedge clk);
        start8 = 1'b1; n8 = 8'd200; d8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        start8 = 1'b1; n8 = 8'd50; d8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("midrun_done", {31'd0, done8}, 1);
        chk("midrun_q", {24'd0, q8}, 200 / 7);
        chk("midrun_r", {24'd0, r8}, 200 % 7);
        @(negedge clk);
        chk("midrun_no_second", {31'd0, busy8 | done8}, 0);

        // Reset while holding a result clears outputs immediately
        op8(8'd77, 8'd5, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_idle_q", {24'd0, q8}, 0);
        chk("arst_idle_r", {24'd0, r8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-RUN: outputs 0 at once, no done afterwards
        @(negedge clk);
        start8 = 1'b1; n8 = 8'd100; d8 = 8'd30;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_arst_busy", {31'd0, busy8}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run_busy", {31'd0, busy8}, 0);
        chk("arst_run_done", {31'd0, done8}, 0);
        chk("arst_run_q", {24'd0, q8}, 0);
        chk("arst_run_dbz", {31'd0, dbz8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) done_seen = 1;
        end
        chk("arst_no_done", {31'd0, done_seen}, 0);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] rn, rd;
            rn = 8'($urandom);
            rd = 8'($urandom);
            if ($urandom_range(0, 31) == 0) rd = 8'd0;
            op8(rn, rd, ($urandom_range(0, 1) == 1) && (i > 0));
        end
        for (int i = 0; i < 20; i++) begin
            op16(16'($urandom), 16'($urandom_range(1, 65535) >> $urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised, multi-cycle unsigned integer divider: computes quotient and remainder of an N-bit dividend by an N-bit divisor using a restoring shift-subtract loop, one quotient bit per clock. It is the sequential, width-generic successor to the team's 8-bit combinational divider. It sits behind a start/done handshake so an ALU or lab-level controller can issue operations and collect results. Divide-by-zero is flagged explicitly instead of producing undefined outputs.

## Interface
- WIDTH, 8, operand/result width in bits (legal range 2..32)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- n  input  WIDTH  dividend, captured on the accepting edge
- d  input  WIDTH  divisor, captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, results valid
- q  output  WIDTH  quotient, held until the next accepted start
- r  output  WIDTH  remainder, held until the next accepted start
- div_by_zero  output  1  set with done when captured d was 0; held with q/r

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch n into the quotient shift register and d into the divisor register; clear the partial remainder (WIDTH+1 bits); load the step counter with WIDTH; clear q, r, and div_by_zero.
  - If d != 0, go to RUN.
  - If d == 0, go to DONE with q = all ones, r = n, and div_by_zero = 1.
- RUN, each cycle: shift {rem, qreg} left by 1 and compute trial = rem − divisor.
  - If trial is non-negative (MSB 0): rem = trial and the new qreg LSB = 1.
  - Otherwise: rem is kept and the new qreg LSB = 0.
  - Decrement the counter. At 0, transfer qreg to q and rem[WIDTH-1:0] to r, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE, unless start=1, which is accepted in the same cycle (back-to-back).
- start while in RUN is ignored. No queuing; the operation in flight is unaffected.
- All arithmetic is unsigned. rem is WIDTH+1 bits so the trial subtraction never loses the borrow.
- Invariant on completion: n == q*d + r and r < d, whenever d != 0.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state=IDLE; busy, done, q, r, div_by_zero and all internal registers = 0. The in-flight operation is discarded.
- Accepting edge = E. Normal case: busy high from E+1 through the edge after which done rises. done is high in cycle E+WIDTH+1 (i.e. WIDTH RUN cycles, then one DONE cycle). Latency start→done = WIDTH+1 cycles.
- Divide-by-zero: done high in cycle E+1 (latency 1); busy stays 0.
- busy is registered: busy=1 exactly while state==RUN.
- q, r, and div_by_zero change only at completion or on an accepted start (cleared), never during RUN iterations.
- Throughput: one operation per WIDTH+1 cycles using back-to-back start in DONE.

## Structure
- Package div_pkg holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the counter-width helper constant, $clog2(WIDTH+1).
- Sub-module div_step (combinational, parametrised by WIDTH): takes rem, qreg MSB, and divisor; returns the next rem and the quotient bit. It is instantiated once inside seq_divider and is separately unit-testable.
- Top module: state register, counter, operand/shift registers, output registers.

## Test plan
- WIDTH=8, n=100, d=30, start pulse → done exactly 9 cycles later; q=3, r=10, div_by_zero=0.
- WIDTH=8, n=12, d=13 → q=0, r=12. Then n=255, d=1 issued back-to-back in the DONE cycle → q=255, r=0, with done 9 cycles after the second start.
- WIDTH=8, n=7, d=0 → done in the next cycle, busy never high; q=255, r=7, div_by_zero=1. A following 9/3 → q=3, r=0, div_by_zero cleared.
- WIDTH=16, n=50000, d=7 → done after 17 cycles; q=7142, r=6.
- Start pulsed again mid-RUN with different operands → ignored; result matches the first operands. rst_n pulsed low mid-RUN → all outputs 0 immediately, no done afterwards.
- Random sweep, WIDTH=8, 1000 pairs → q*d+r==n and r<d for every d != 0.
